oc8051_irq_ctrl: RTL and testbench

//  Interrupt controller fed by the timer/counter overflow flags and the external/serial sources.

---
 rtl/oc8051_irq_ctrl_pkg.sv | 53 +++++
 rtl/oc8051_irq_ctrl_if.sv | 36 +++
 rtl/oc8051_irq_prio.sv | 31 +++
 rtl/oc8051_irq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_oc8051_irq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oc8051_irq_ctrl_pkg.sv
// Shared constants and types for the oc8051 interrupt controller: SFR addresses,
// TCON bit positions, source indices and the priority-encoder result type.
package oc8051_irq_ctrl_pkg;

   localparam logic [7:0] SfrTcon = 8'h88;
   localparam logic [7:0] SfrIe   = 8'hA8;
   localparam logic [7:0] SfrIp   = 8'hB8;

   localparam logic [7:0] TconRst = 8'h00;
   localparam logic [7:0] IeRst   = 8'h00;
   localparam logic [7:0] IpRst   = 8'h00;

   // Reserved bits read back as zero.
   localparam logic [7:0] IeMask  = 8'h9F;
   localparam logic [7:0] IpMask  = 8'h1F;

   localparam int TconIt0 = 0;
   localparam int TconIe0 = 1;
   localparam int TconIt1 = 2;
   localparam int TconIe1 = 3;
   localparam int TconTr0 = 4;
   localparam int TconTf0 = 5;
   localparam int TconTr1 = 6;
   localparam int TconTf1 = 7;

   localparam int NumSrc = 5;

   typedef enum logic [2:0] {
      SrcIe0  = 3'd0,
      SrcTf0  = 3'd1,
      SrcIe1  = 3'd2,
      SrcTf1  = 3'd3,
      SrcUart = 3'd4
   } irq_src_e;

   typedef enum logic [1:0] {
      StIdle,
      StLo,
      StHi,
      StLoHi
   } is_state_e;

   typedef struct packed {
      logic     valid;
      logic     level;
      irq_src_e idx;
   } prio_res_t;

   function automatic logic [7:0] vec_of(input logic [7:0] base, input irq_src_e src);
      return base + {2'b00, src, 3'b000};
   endfunction

endpackage

// File: rtl/oc8051_irq_ctrl_if.sv
// SFR bus, interrupt sources and CPU handshake of the oc8051 interrupt controller.
// The master side (CPU/peripherals) drives requests; the slave side is the controller.
interface oc8051_irq_ctrl_if;

   logic [7:0] wr_addr;
   logic [7:0] rd_addr;
   logic [7:0] data_in;
   logic       bit_in;
   logic       wr;
   logic       wr_bit;
   logic       int0_n;
   logic       int1_n;
   logic       tf0_in;
   logic       tf1_in;
   logic       uart_int;
   logic       int_ack;
   logic       reti;
   logic       int_req;
   logic [7:0] int_vec;
   logic       tr0;
   logic       tr1;
   logic [7:0] data_out;

   modport master (
      output wr_addr, rd_addr, data_in, bit_in, wr, wr_bit,
      output int0_n, int1_n, tf0_in, tf1_in, uart_int, int_ack, reti,
      input  int_req, int_vec, tr0, tr1, data_out
   );

   modport slave (
      input  wr_addr, rd_addr, data_in, bit_in, wr, wr_bit,
      input  int0_n, int1_n, tf0_in, tf1_in, uart_int, int_ack, reti,
      output int_req, int_vec, tr0, tr1, data_out
   );

endinterface

// File: rtl/oc8051_irq_prio.sv
// Combinational 5-source, 2-level priority encoder: high-priority (IP=1) pending
// sources beat low ones; within a level the lowest source index wins.
module oc8051_irq_prio
   import oc8051_irq_ctrl_pkg::*;
(
   input  logic [4:0] pending,
   input  logic [4:0] ip,
   output prio_res_t  res
);

   logic [4:0] hi_pend;
   logic [4:0] lo_pend;

   always_comb begin
      hi_pend = pending & ip;
      lo_pend = pending & ~ip;
      res     = '{valid: 1'b0, level: 1'b0, idx: SrcIe0};
      // Scan downwards so the lowest index is the last (winning) assignment.
      for (int i = NumSrc - 1; i >= 0; i--) begin
         if (lo_pend[i]) begin
            res = '{valid: 1'b1, level: 1'b0, idx: irq_src_e'(3'(i))};
         end
      end
      for (int i = NumSrc - 1; i >= 0; i--) begin
         if (hi_pend[i]) begin
            res = '{valid: 1'b1, level: 1'b1, idx: irq_src_e'(3'(i))};
         end
      end
   end

endmodule

// File: rtl/oc8051_irq_ctrl.sv
// oc8051 interrupt controller: owns TCON/IE/IP, arbitrates 5 sources over 2 nested
// priority levels. Define OC8051_IRQ_SYNC_EN to add 2-flop synchronizers on int0_n/int1_n.
module oc8051_irq_ctrl
   import oc8051_irq_ctrl_pkg::*;
#(
   parameter logic [7:0] VEC_BASE = 8'h03
) (
   input logic               clk,
   input logic               rst,
   oc8051_irq_ctrl_if.slave  bus
);

   logic int0_pin;
   logic int1_pin;

`ifdef OC8051_IRQ_SYNC_EN
   logic [1:0] int0_sync_q;
   logic [1:0] int1_sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int0_sync_q <= 2'b11;
         int1_sync_q <= 2'b11;
      end else begin
         int0_sync_q <= {int0_sync_q[0], bus.int0_n};
         int1_sync_q <= {int1_sync_q[0], bus.int1_n};
      end
   end

   assign int0_pin = int0_sync_q[1];
   assign int1_pin = int1_sync_q[1];
`else
   assign int0_pin = bus.int0_n;
   assign int1_pin = bus.int1_n;
`endif

   logic [7:0] tcon_q, tcon_d;
   logic [7:0] ie_q, ie_d;
   logic [7:0] ip_q, ip_d;
   logic       tf0_prev_q, tf1_prev_q;
   logic       int0_prev_q, int1_prev_q;
   is_state_e  is_state_q, is_state_d;
   logic       int_req_q, int_req_d;
   logic [7:0] int_vec_q, int_vec_d;
   irq_src_e   int_src_q, int_src_d;
   logic       int_lvl_q, int_lvl_d;
   logic [7:0] data_out_q, data_out_d;

   logic       ack;
   logic [2:0] bit_sel;
   logic       byte_wr, bit_wr;
   logic [7:0] bit_wr_sfr;
   logic [4:0] flags;
   logic [4:0] pending;
   prio_res_t  cand;
   logic       hi_is, lo_is;
   logic       allowed;
   logic       hi_n, lo_n;

   assign ack        = bus.int_ack & int_req_q;
   assign bit_sel    = bus.wr_addr[2:0];
   assign byte_wr    = bus.wr & ~bus.wr_bit;
   assign bit_wr     = bus.wr & bus.wr_bit;
   assign bit_wr_sfr = {bus.wr_addr[7:3], 3'b000};

   // Order matters: software write, then ack clear, then hardware set wins.
   always_comb begin
      tcon_d = tcon_q;
      if (byte_wr && bus.wr_addr == SfrTcon) begin
         tcon_d = bus.data_in;
      end else if (bit_wr && bit_wr_sfr == SfrTcon) begin
         tcon_d[bit_sel] = bus.bit_in;
      end
      if (ack) begin
         case (int_src_q)
            SrcIe0:  tcon_d[TconIe0] = 1'b0;
            SrcTf0:  tcon_d[TconTf0] = 1'b0;
            SrcIe1:  tcon_d[TconIe1] = 1'b0;
            SrcTf1:  tcon_d[TconTf1] = 1'b0;
            default: ;
         endcase
      end
      if (bus.tf0_in && !tf0_prev_q) tcon_d[TconTf0] = 1'b1;
      if (bus.tf1_in && !tf1_prev_q) tcon_d[TconTf1] = 1'b1;
      // Level mode overrides any write or ack clear of IEx.
      if (tcon_d[TconIt0]) begin
         if (int0_prev_q && !int0_pin) tcon_d[TconIe0] = 1'b1;
      end else begin
         tcon_d[TconIe0] = ~int0_pin;
      end
      if (tcon_d[TconIt1]) begin
         if (int1_prev_q && !int1_pin) tcon_d[TconIe1] = 1'b1;
      end else begin
         tcon_d[TconIe1] = ~int1_pin;
      end
   end

   always_comb begin
      ie_d = ie_q;
      ip_d = ip_q;
      if (byte_wr && bus.wr_addr == SfrIe) ie_d = bus.data_in;
      if (bit_wr && bit_wr_sfr == SfrIe)   ie_d[bit_sel] = bus.bit_in;
      if (byte_wr && bus.wr_addr == SfrIp) ip_d = bus.data_in;
      if (bit_wr && bit_wr_sfr == SfrIp)   ip_d[bit_sel] = bus.bit_in;
      ie_d = ie_d & IeMask;
      ip_d = ip_d & IpMask;
   end

   assign flags   = {bus.uart_int, tcon_q[TconTf1], tcon_q[TconIe1],
                     tcon_q[TconTf0], tcon_q[TconIe0]};
   assign pending = flags & ie_q[4:0] & {5{ie_q[7]}};

   oc8051_irq_prio u_prio (
      .pending (pending),
      .ip      (ip_q[4:0]),
      .res     (cand)
   );

   assign hi_is   = (is_state_q == StHi) || (is_state_q == StLoHi);
   assign lo_is   = (is_state_q == StLo) || (is_state_q == StLoHi);
   assign allowed = cand.valid & (cand.level ? ~hi_is : ~(hi_is | lo_is));

   // In-service tracking: reti retires the innermost level, ack opens a new one.
   always_comb begin
      hi_n = hi_is;
      lo_n = lo_is;
      if (bus.reti) begin
         if (hi_n) hi_n = 1'b0;
         else      lo_n = 1'b0;
      end
      if (ack) begin
         if (int_lvl_q) hi_n = 1'b1;
         else           lo_n = 1'b1;
      end
      unique case ({hi_n, lo_n})
         2'b00: is_state_d = StIdle;
         2'b01: is_state_d = StLo;
         2'b10: is_state_d = StHi;
         2'b11: is_state_d = StLoHi;
      endcase
   end

   // A posted request keeps its vector until acknowledged.
   always_comb begin
      int_req_d = int_req_q;
      int_vec_d = int_vec_q;
      int_src_d = int_src_q;
      int_lvl_d = int_lvl_q;
      if (int_req_q) begin
         if (bus.int_ack) int_req_d = 1'b0;
      end else if (allowed) begin
         int_req_d = 1'b1;
         int_vec_d = vec_of(VEC_BASE, cand.idx);
         int_src_d = cand.idx;
         int_lvl_d = cand.level;
      end
   end

   // Reads use next-state values so same-cycle writes are bypassed.
   always_comb begin
      data_out_d = 8'h00;
      if (bus.rd_addr == SfrTcon)    data_out_d = tcon_d;
      else if (bus.rd_addr == SfrIe) data_out_d = ie_d;
      else if (bus.rd_addr == SfrIp) data_out_d = ip_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcon_q      <= TconRst;
         ie_q        <= IeRst;
         ip_q        <= IpRst;
         tf0_prev_q  <= 1'b0;
         tf1_prev_q  <= 1'b0;
         int0_prev_q <= 1'b0;
         int1_prev_q <= 1'b0;
         is_state_q  <= StIdle;
         int_req_q   <= 1'b0;
         int_vec_q   <= 8'h00;
         int_src_q   <= SrcIe0;
         int_lvl_q   <= 1'b0;
         data_out_q  <= 8'h00;
      end else begin
         tcon_q      <= tcon_d;
         ie_q        <= ie_d;
         ip_q        <= ip_d;
         tf0_prev_q  <= bus.tf0_in;
         tf1_prev_q  <= bus.tf1_in;
         int0_prev_q <= int0_pin;
         int1_prev_q <= int1_pin;
         is_state_q  <= is_state_d;
         int_req_q   <= int_req_d;
         int_vec_q   <= int_vec_d;
         int_src_q   <= int_src_d;
         int_lvl_q   <= int_lvl_d;
         data_out_q  <= data_out_d;
      end
   end

   assign bus.int_req  = int_req_q;
   assign bus.int_vec  = int_vec_q;
   assign bus.tr0      = tcon_q[TconTr0];
   assign bus.tr1      = tcon_q[TconTr1];
   assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_oc8051_irq_ctrl.sv
// Scoreboard bench for oc8051_irq_ctrl: stimulus queues expected vectors and read data,
// a negedge monitor pops and compares when int_req rises or a read result is due.
module tb_oc8051_irq_ctrl;

   logic clk;
   logic rst;

   oc8051_irq_ctrl_if bus ();

   oc8051_irq_ctrl #(.VEC_BASE(8'h03)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         total = 0;
   int         bad = 0;
   logic [7:0] vec_q[$];
   logic [7:0] rd_q[$];
   logic       rd_issue;
   logic       rd_pend;
   logic       req_prev = 1'b0;
   logic [7:0] vec_hold = 8'h00;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h want %02h", name, act, exp);
      end
   endtask

   always @(posedge clk) rd_pend <= rd_issue;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (rd_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_underflow: got %02h want none", bus.data_out);
         end else begin
            check("rd_data", bus.data_out, rd_q.pop_front());
         end
      end
      if (bus.int_req && !req_prev) begin
         if (vec_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: got vec %02h want no request", bus.int_vec);
         end else begin
            check("int_vec", bus.int_vec, vec_q.pop_front());
         end
         vec_hold = bus.int_vec;
      end else if (bus.int_req && req_prev) begin
         check("vec_stable", bus.int_vec, vec_hold);
      end
      req_prev = bus.int_req;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
      bus.wr_addr = a;
      bus.data_in = d;
      bus.wr_bit  = 1'b0;
      bus.wr      = 1'b1;
      @(negedge clk);
      bus.wr      = 1'b0;
   endtask

   task automatic wr_bitt(input logic [7:0] a, input logic b);
      bus.wr_addr = a;
      bus.bit_in  = b;
      bus.wr_bit  = 1'b1;
      bus.wr      = 1'b1;
      @(negedge clk);
      bus.wr      = 1'b0;
      bus.wr_bit  = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp);
      rd_q.push_back(exp);
      bus.rd_addr = a;
      rd_issue    = 1'b1;
      @(negedge clk);
      rd_issue    = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.int_ack = 1'b1;
      @(negedge clk);
      bus.int_ack = 1'b0;
   endtask

   task automatic pulse_reti();
      bus.reti = 1'b1;
      @(negedge clk);
      bus.reti = 1'b0;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!bus.int_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      check(name, {7'b0, bus.int_req}, 8'h01);
   endtask

   initial begin
      rst          = 1'b1;
      rd_issue     = 1'b0;
      bus.wr_addr  = 8'h00;
      bus.rd_addr  = 8'h00;
      bus.data_in  = 8'h00;
      bus.bit_in   = 1'b0;
      bus.wr       = 1'b0;
      bus.wr_bit   = 1'b0;
      bus.int0_n   = 1'b1;
      bus.int1_n   = 1'b1;
      bus.tf0_in   = 1'b0;
      bus.tf1_in   = 1'b0;
      bus.uart_int = 1'b0;
      bus.int_ack  = 1'b0;
      bus.reti     = 1'b0;
      cyc(3);
      rst = 1'b0;

      check("rst_req", {7'b0, bus.int_req}, 8'h00);
      check("rst_vec", bus.int_vec, 8'h00);
      check("rst_dout", bus.data_out, 8'h00);
      check("rst_tr", {6'b0, bus.tr1, bus.tr0}, 8'h00);
      rd(8'h88, 8'h00);
      rd(8'hA8, 8'h00);
      rd(8'hB8, 8'h00);

      // Timer 0 overflow.
      wr_byte(8'hA8, 8'h82);
      vec_q.push_back(8'h0B);
      bus.tf0_in = 1'b1;
      wait_req("t0_req");
      rd(8'h88, 8'h20);
      pulse_ack();
      check("t0_ack_req", {7'b0, bus.int_req}, 8'h00);
      rd(8'h88, 8'h00);
      pulse_reti();
      bus.tf0_in = 1'b0;
      cyc(2);

      // INT0 edge mode, then level mode.
      wr_byte(8'h88, 8'h01);
      wr_byte(8'hA8, 8'h81);
      vec_q.push_back(8'h03);
      bus.int0_n = 1'b0;
      wait_req("ie0_edge_req");
      pulse_ack();
      check("ie0_edge_ack", {7'b0, bus.int_req}, 8'h00);
      rd(8'h88, 8'h01);
      pulse_reti();
      bus.int0_n = 1'b1;
      cyc(2);
      wr_byte(8'h88, 8'h00);
      vec_q.push_back(8'h03);
      bus.int0_n = 1'b0;
      wait_req("ie0_lvl_req");
      pulse_ack();
      check("ie0_lvl_ack", {7'b0, bus.int_req}, 8'h00);
      rd(8'h88, 8'h02);
      bus.int0_n = 1'b1;
      cyc(1);
      pulse_reti();
      cyc(2);

      // Nesting: low TF1 in service, high INT0 preempts.
      wr_byte(8'h88, 8'h01);
      wr_byte(8'hA8, 8'h89);
      wr_byte(8'hB8, 8'h00);
      vec_q.push_back(8'h1B);
      bus.tf1_in = 1'b1;
      wait_req("nest_lo_req");
      pulse_ack();
      check("nest_lo_ack", {7'b0, bus.int_req}, 8'h00);
      wr_byte(8'hB8, 8'h01);
      vec_q.push_back(8'h03);
      bus.int0_n = 1'b0;
      wait_req("nest_hi_req");
      pulse_ack();
      check("nest_hi_ack", {7'b0, bus.int_req}, 8'h00);
      bus.tf1_in = 1'b0;
      cyc(1);
      bus.tf1_in = 1'b1;
      cyc(3);
      check("hi_block", {7'b0, bus.int_req}, 8'h00);
      rd(8'h88, 8'h81);
      pulse_reti();
      cyc(3);
      check("lo_block", {7'b0, bus.int_req}, 8'h00);
      vec_q.push_back(8'h1B);
      pulse_reti();
      wait_req("nest_resume_req");
      pulse_ack();
      pulse_reti();
      bus.tf1_in = 1'b0;
      bus.int0_n = 1'b1;
      cyc(2);

      // Same-level arbitration: TF0 beats IE1.
      wr_byte(8'hB8, 8'h00);
      wr_byte(8'h88, 8'h05);
      wr_byte(8'hA8, 8'h87);
      vec_q.push_back(8'h0B);
      vec_q.push_back(8'h13);
      bus.tf0_in = 1'b1;
      bus.int1_n = 1'b0;
      wait_req("arb_first_req");
      pulse_ack();
      pulse_reti();
      wait_req("arb_second_req");
      pulse_ack();
      pulse_reti();
      bus.tf0_in = 1'b0;
      bus.int1_n = 1'b1;
      cyc(2);

      // Hardware set beats software clear; read bypass; bit writes.
      wr_byte(8'hA8, 8'h00);
      bus.wr_addr = 8'h88;
      bus.data_in = 8'h00;
      bus.wr_bit  = 1'b0;
      bus.wr      = 1'b1;
      bus.tf1_in  = 1'b1;
      cyc(1);
      bus.wr = 1'b0;
      rd(8'h88, 8'h80);
      bus.wr_addr = 8'hA8;
      bus.data_in = 8'h65;
      bus.wr      = 1'b1;
      rd(8'hA8, 8'h05);
      bus.wr = 1'b0;
      wr_bitt(8'h8C, 1'b1);
      check("tr0_set", {7'b0, bus.tr0}, 8'h01);
      rd(8'h88, 8'h90);
      wr_bitt(8'h8E, 1'b1);
      check("tr1_set", {7'b0, bus.tr1}, 8'h01);
      rd(8'h90, 8'h00);
      rd(8'h88, 8'hD0);
      wr_bitt(8'hBC, 1'b1);
      rd(8'hB8, 8'h10);
      wr_byte(8'hB8, 8'h00);

      // EA gating, software-generated interrupt, reset mid-request.
      bus.tf1_in = 1'b0;
      wr_byte(8'hA8, 8'h1F);
      wr_byte(8'h88, 8'hBF);
      bus.uart_int = 1'b1;
      cyc(4);
      check("ea_off", {7'b0, bus.int_req}, 8'h00);
      rd(8'h88, 8'hBF);
      vec_q.push_back(8'h03);
      wr_byte(8'hA8, 8'h9F);
      wait_req("sw_req");
      rst = 1'b1;
      cyc(1);
      check("rst_mid_req", {7'b0, bus.int_req}, 8'h00);
      check("rst_mid_vec", bus.int_vec, 8'h00);
      check("rst_mid_dout", bus.data_out, 8'h00);
      check("rst_mid_tr", {6'b0, bus.tr1, bus.tr0}, 8'h00);
      rst = 1'b0;
      bus.uart_int = 1'b0;
      rd(8'h88, 8'h00);
      rd(8'hA8, 8'h00);
      cyc(3);

      check("vec_q_left", 8'(vec_q.size()), 8'h00);
      check("rd_q_left", 8'(rd_q.size()), 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
